i2s_tx_multich_serializer: RTL and testbench
============================================

# i2s_tx_multich_serializer

Parametrised multi-lane transmit serializer for the uDMA I2S peripheral. It generalises the 2-channel DSP TX channel to NUM_CH parallel data lanes, each word up to DATA_W bits, with double-buffered words, a one-time frame-sync offset, and explicit underrun reporting. It sits between the TX FIFO (valid/ready, words in lane order) and the SD output pads, and runs in the `sck_i` domain.

## Interface
- NUM_CH, 2, number of SD lanes (1..8)
- DATA_W, 32, maximum word width
- OFFSET_W, 9, width of the frame-sync offset counter
- sck_i  in  1  serial bit clock; all logic on posedge
- rstn_i  in  1  reset, asynchronous, active-low
- cfg_en_i  in  1  enable; low = synchronous clear to IDLE
- cfg_num_bits_i  in  $clog2(DATA_W)  word length minus 1
- cfg_num_ch_i  in  max(1,$clog2(NUM_CH))  active lanes minus 1
- cfg_lsb_first_i  in  1  0 = MSB first, 1 = LSB first
- cfg_offset_i  in  OFFSET_W  zero-bit cycles between the frame-sync edge and the first bit
- ws_i  in  1  frame sync from the clock generator
- fifo_data_i  in  DATA_W  TX word
- fifo_valid_i  in  1  word valid
- fifo_ready_o  out  1  word accepted when valid & ready at posedge
- sd_o  out  NUM_CH  serial data lanes, registered
- ready_to_send_o  out  1  buffer primed; master may start ws
- underrun_o  out  1  one-cycle pulse at a starved word start
- err_o  out  1  sticky underrun flag, cleared by cfg_en_i low

## Operation
- States:
  - IDLE → FILL when cfg_en_i is high.
  - FILL → ARMED once the shadow buffer holds cfg_num_ch_i+1 words.
  - ARMED → OFFSET on a ws rising edge (ws_i=1 and registered ws_q=0) with cfg_offset_i≠0.
  - ARMED → SHIFT on the same edge when cfg_offset_i=0.
  - OFFSET → SHIFT after cfg_offset_i cycles.
  - SHIFT stays in SHIFT.
- cfg_en_i low in any state: IDLE on the next edge. The shadow count, counters, sd_o, err_o and ready_to_send_o all clear.
- Shadow fill: word j accepted goes to shadow[j] in lane order. fifo_ready_o = (FILL or ARMED or OFFSET or SHIFT) and shadow count ≤ cfg_num_ch_i. It does not depend on fifo_valid_i.
- Word start (first bit of every word in SHIFT):
  - If the shadow is full: active[c] ← shadow[c], shadow count ← 0, and sd_o[c] takes its first bit directly from shadow[c].
  - If the shadow is not full: active ← 0, sd_o ← 0, underrun_o pulses, err_o sets. The partial shadow is kept and filling continues, so lane order is preserved.
- Bit order:
  - MSB first: indices cfg_num_bits_i down to 0.
  - LSB first: indices 0 up to cfg_num_bits_i.
  - Bits above cfg_num_bits_i are never output.
- After the first word, words run back-to-back with no gap. ws_i is ignored after the first frame-sync edge, and the offset is applied only once per enable.
- Lanes ≥ cfg_num_ch_i+1 output 0 and consume no FIFO words.
- ready_to_send_o is high in ARMED, OFFSET and SHIFT.

## Timing
- Reset values: sd_o=0, fifo_ready_o=0, ready_to_send_o=0, underrun_o=0, err_o=0, state IDLE.
- The ws rising edge is detected at edge k:
  - With offset N≠0, sd_o is 0 after edges k..k+N-1 and the first bit is registered at edge k+N.
  - With offset 0, the first bit is registered at edge k.
- A word occupies exactly cfg_num_bits_i+1 cycles. The next word start follows the last bit on the very next edge.
- Refill window: the full word period. The FIFO must supply cfg_num_ch_i+1 words per word period to avoid underrun.
- A handshake on the same edge as a word start is not possible when the shadow is full (ready=0). When the shadow is not full, an accepted word lands in the shadow and the start underruns.
- Configuration changes are only legal while cfg_en_i=0.

## Structure
- Package i2s_tx_pkg holds:
  - the state enum (IDLE, FILL, ARMED, OFFSET, SHIFT);
  - the NUM_CH_MAX=8 constant;
  - the bit-index helper function (index from count and lsb_first).
- Sub-module i2s_tx_lane, instantiated NUM_CH times, owns per-lane storage: the shadow word, the active word and the bit mux.
- The top level holds the FSM, the bit counter, the offset counter, the shadow count and the ws edge detect.

## Test plan
- NUM_CH=2, 16-bit MSB-first, offset 0: preload 0xA5A5, 0x0F0F, then ws edge → sd_o[0] = 1010010110100101 and sd_o[1] = 0000111100001111, starting the cycle after the ws edge.
- LSB-first 8-bit, offset 3: word 0x81 → three zero cycles, then 1,0,0,0,0,0,0,1 on lane 0.
- Four lanes, continuous stream of 12 words at full rate: three back-to-back frames, no gaps, underrun_o never asserts.
- Valid withheld for one word period mid-stream: one all-zero word, a single underrun_o pulse, err_o stays 1; the next supplied words resume in correct lane order.
- cfg_en_i dropped mid-word, then raised again: IDLE next edge with all outputs 0; after refill and a new ws edge, the new words and the offset are applied again.
- rstn_i asserted mid-SHIFT: all outputs 0 immediately (asynchronously), with no FIFO handshake until FILL.

Source files
------------

// File: rtl/i2s_tx_pkg.sv
// Shared definitions for the multi-lane I2S transmit serializer:
// FSM state encodings, lane limit and the bit-order helper.
package i2s_tx_pkg;

  localparam int NUM_CH_MAX = 8;
  localparam int IDX_W      = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FILL   = 3'd1;
  localparam logic [2:0] ST_ARMED  = 3'd2;
  localparam logic [2:0] ST_OFFSET = 3'd3;
  localparam logic [2:0] ST_SHIFT  = 3'd4;

  // Maps the position within a word to the data bit sent at that position.
  function automatic logic [IDX_W-1:0] bit_index(
    input logic [IDX_W-1:0] cnt,
    input logic [IDX_W-1:0] num_bits,
    input logic             lsb_first
  );
    return lsb_first ? cnt : (num_bits - cnt);
  endfunction

endpackage

// File: rtl/i2s_tx_multich_serializer_lane.sv
// One SD lane: the shadow word being refilled from the FIFO, the word
// currently on the wire, and the registered serial output bit.
module i2s_tx_lane
  import i2s_tx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NB_W   = 5
) (
  input  logic              sck_i,
  input  logic              rstn_i,
  input  logic              clr_i,
  input  logic              lane_en_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              take_i,
  input  logic              starve_i,
  input  logic              shift_i,
  input  logic [NB_W-1:0]   bit_idx_i,
  output logic              sd_o
);

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] active_q, active_d;
  logic              sd_q, sd_d;

  // On a word start the first bit comes straight from the shadow word,
  // since the active register only picks it up on that same edge.
  always_comb begin
    shadow_d = wr_en_i ? wr_data_i : shadow_q;
    active_d = active_q;
    if (clr_i || starve_i) begin
      active_d = '0;
    end else if (take_i) begin
      active_d = shadow_q;
    end
    sd_d = 1'b0;
    if (!clr_i && shift_i && lane_en_i && !starve_i) begin
      sd_d = take_i ? shadow_q[bit_idx_i] : active_q[bit_idx_i];
    end
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      shadow_q <= '0;
      active_q <= '0;
      sd_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      sd_q     <= sd_d;
    end
  end

  assign sd_o = sd_q;

endmodule

// File: rtl/i2s_tx_multich_serializer.sv
// Multi-lane I2S TX serializer: FSM, frame-sync edge detect, one-time
// offset, bit counter and shadow fill count; lanes hold the data words.
module i2s_tx_multich_serializer
  import i2s_tx_pkg::*;
#(
  parameter int  NUM_CH   = 2,
  parameter int  DATA_W   = 32,
  parameter int  OFFSET_W = 9,
  localparam int NB_W     = $clog2(DATA_W),
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                sck_i,
  input  logic                rstn_i,
  input  logic                cfg_en_i,
  input  logic [NB_W-1:0]     cfg_num_bits_i,
  input  logic [CH_W-1:0]     cfg_num_ch_i,
  input  logic                cfg_lsb_first_i,
  input  logic [OFFSET_W-1:0] cfg_offset_i,
  input  logic                ws_i,
  input  logic [DATA_W-1:0]   fifo_data_i,
  input  logic                fifo_valid_i,
  output logic                fifo_ready_o,
  output logic [NUM_CH-1:0]   sd_o,
  output logic                ready_to_send_o,
  output logic                underrun_o,
  output logic                err_o
);

  localparam int CNT_W = CH_W + 1;

  logic [2:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OFFSET_W-1:0] off_q, off_d;
  logic [NB_W-1:0]     bit_q, bit_d;
  logic                ws_q;
  logic                underrun_q, underrun_d;
  logic                err_q, err_d;

  logic             ws_rise, full, hs;
  logic             word_start, shifting, take, starve;
  logic [NB_W-1:0]  bit_idx;
  logic [CNT_W-1:0] num_ch_ext;

  assign num_ch_ext = {1'b0, cfg_num_ch_i};
  assign ws_rise    = ws_i & ~ws_q;
  assign full       = (cnt_q == num_ch_ext + 1'b1);

  assign fifo_ready_o    = (state_q != ST_IDLE) && (cnt_q <= num_ch_ext);
  assign ready_to_send_o = (state_q == ST_ARMED) || (state_q == ST_OFFSET) ||
                           (state_q == ST_SHIFT);
  assign hs = fifo_valid_i & fifo_ready_o;

  // A word start is either the first word (leaving ARMED or OFFSET) or the
  // edge right after the last bit of the previous word.
  assign word_start = ((state_q == ST_ARMED) && ws_rise && (cfg_offset_i == '0)) ||
                      ((state_q == ST_OFFSET) && (off_q == '0)) ||
                      ((state_q == ST_SHIFT) && (bit_q == '0));
  assign shifting   = word_start || (state_q == ST_SHIFT);
  assign take       = word_start & full;
  assign starve     = word_start & ~full;

  assign bit_idx = NB_W'(bit_index(IDX_W'(bit_q), IDX_W'(cfg_num_bits_i), cfg_lsb_first_i));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    off_d      = off_q;
    bit_d      = bit_q;
    err_d      = err_q;
    underrun_d = 1'b0;
    if (!cfg_en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      off_d   = '0;
      bit_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_FILL;
        ST_FILL:  if (full) state_d = ST_ARMED;
        ST_ARMED: begin
          if (ws_rise) begin
            if (cfg_offset_i == '0) begin
              state_d = ST_SHIFT;
            end else begin
              state_d = ST_OFFSET;
              off_d   = cfg_offset_i - OFFSET_W'(1);
            end
          end
        end
        ST_OFFSET: begin
          if (off_q == '0) state_d = ST_SHIFT;
          else             off_d   = off_q - OFFSET_W'(1);
        end
        default: state_d = state_q;
      endcase
      if (shifting) begin
        bit_d = (bit_q == cfg_num_bits_i) ? '0 : bit_q + 1'b1;
      end
      if (take)    cnt_d = '0;
      else if (hs) cnt_d = cnt_q + 1'b1;
      if (starve) begin
        underrun_d = 1'b1;
        err_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      off_q      <= '0;
      bit_q      <= '0;
      ws_q       <= 1'b0;
      underrun_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      off_q      <= off_d;
      bit_q      <= bit_d;
      ws_q       <= ws_i;
      underrun_q <= underrun_d;
      err_q      <= err_d;
    end
  end

  assign underrun_o = underrun_q;
  assign err_o      = err_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    localparam logic [CNT_W-1:0] LANE_ID = CNT_W'(c);
    i2s_tx_lane #(
      .DATA_W (DATA_W),
      .NB_W   (NB_W)
    ) u_lane (
      .sck_i     (sck_i),
      .rstn_i    (rstn_i),
      .clr_i     (~cfg_en_i),
      .lane_en_i (num_ch_ext >= LANE_ID),
      .wr_en_i   (hs && (cnt_q == LANE_ID)),
      .wr_data_i (fifo_data_i),
      .take_i    (take),
      .starve_i  (starve),
      .shift_i   (shifting),
      .bit_idx_i (bit_idx),
      .sd_o      (sd_o[c])
    );
  end

endmodule

// File: tb/tb_i2s_tx_multich_serializer.sv
// Directed self-checking bench for the multi-lane I2S TX serializer,
// with a queue-backed FIFO source feeding the DUT.
module tb_i2s_tx_multich_serializer;

  logic        sck = 1'b0;
  logic        rstn = 1'b0;
  logic        cfgEn = 1'b0;
  logic [4:0]  cfgNumBits = '0;
  logic [1:0]  cfgNumCh = '0;
  logic        cfgLsbFirst = 1'b0;
  logic [8:0]  cfgOffset = '0;
  logic        ws = 1'b0;
  logic [31:0] fifoData = '0;
  logic        fifoValid = 1'b0;
  logic        fifoReady;
  logic [3:0]  sd;
  logic        readyToSend;
  logic        underrun;
  logic        err;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] txQ[$];
  logic        feedEn = 1'b0;

  i2s_tx_multich_serializer #(
    .NUM_CH   (4),
    .DATA_W   (32),
    .OFFSET_W (9)
  ) dut (
    .sck_i           (sck),
    .rstn_i          (rstn),
    .cfg_en_i        (cfgEn),
    .cfg_num_bits_i  (cfgNumBits),
    .cfg_num_ch_i    (cfgNumCh),
    .cfg_lsb_first_i (cfgLsbFirst),
    .cfg_offset_i    (cfgOffset),
    .ws_i            (ws),
    .fifo_data_i     (fifoData),
    .fifo_valid_i    (fifoValid),
    .fifo_ready_o    (fifoReady),
    .sd_o            (sd),
    .ready_to_send_o (readyToSend),
    .underrun_o      (underrun),
    .err_o           (err)
  );

  always #5 sck = ~sck;

  // The FIFO source pops on an accepted handshake and re-drives on the falling edge.
  always @(posedge sck) begin
    if (fifoValid && fifoReady && txQ.size() != 0) void'(txQ.pop_front());
  end

  always @(negedge sck) begin
    fifoValid = feedEn && (txQ.size() != 0);
    fifoData  = (txQ.size() != 0) ? txQ[0] : 32'd0;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge sck);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] nb, input logic [1:0] nc, input logic lsb,
                               input logic [8:0] off);
    ws     = 1'b0;
    feedEn = 1'b0;
    cfgEn  = 1'b0;
    txQ.delete();
    tick;
    cfgNumBits  = nb;
    cfgNumCh    = nc;
    cfgLsbFirst = lsb;
    cfgOffset   = off;
    cfgEn       = 1'b1;
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (!readyToSend && n < 100) begin
      tick;
      n++;
    end
    checkOutput(tag, 32'(readyToSend), 32'd1);
  endtask

  logic [15:0] exp0, exp1;
  logic [0:10] seq2;
  logic [7:0]  w3[12];
  logic [7:0]  w4[4];
  logic [3:0]  e;
  logic [7:0]  a, b;

  initial begin
    // Reset state
    repeat (2) tick;
    checkOutput("rst_sd", 32'(sd), 32'd0);
    checkOutput("rst_ready", 32'(fifoReady), 32'd0);
    checkOutput("rst_rts", 32'(readyToSend), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    rstn = 1'b1;
    tick;

    // Two lanes, 16-bit MSB first, no offset, then starvation
    applyStimulus(5'd15, 2'd1, 1'b0, 9'd0);
    txQ.push_back(32'h0000A5A5);
    txQ.push_back(32'h00000F0F);
    feedEn = 1'b1;
    waitReady("t1_rts");
    ws   = 1'b1;
    exp0 = 16'b1010010110100101;
    exp1 = 16'b0000111100001111;
    for (int i = 0; i < 16; i++) begin
      tick;
      checkOutput($sformatf("t1_bit%0d", i), 32'(sd), {30'd0, exp1[15-i], exp0[15-i]});
      if (i == 0) checkOutput("t1_no_underrun", 32'(underrun), 32'd0);
    end
    tick;
    checkOutput("t1_underrun", 32'(underrun), 32'd1);
    checkOutput("t1_starved_sd", 32'(sd), 32'd0);
    checkOutput("t1_err", 32'(err), 32'd1);
    tick;
    checkOutput("t1_underrun_pulse", 32'(underrun), 32'd0);
    checkOutput("t1_err_sticky", 32'(err), 32'd1);

    // One lane, 8-bit LSB first, offset 3
    applyStimulus(5'd7, 2'd0, 1'b1, 9'd3);
    checkOutput("t2_err_clr", 32'(err), 32'd0);
    txQ.push_back(32'h00000081);
    feedEn = 1'b1;
    waitReady("t2_rts");
    ws   = 1'b1;
    seq2 = 11'b000_1000_0001;
    for (int j = 0; j < 11; j++) begin
      tick;
      checkOutput($sformatf("t2_cyc%0d", j), 32'(sd), {31'd0, seq2[j]});
    end

    // Four lanes, three back-to-back frames at full rate
    applyStimulus(5'd7, 2'd3, 1'b0, 9'd0);
    w3 = '{8'hC3, 8'h5A, 8'h01, 8'hFE, 8'h80, 8'h7F, 8'h33, 8'hCC,
           8'h96, 8'h69, 8'hF0, 8'h0F};
    for (int k = 0; k < 12; k++) txQ.push_back({24'd0, w3[k]});
    feedEn = 1'b1;
    waitReady("t3_rts");
    ws = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick;
      for (int c = 0; c < 4; c++) begin
        a    = w3[4*(i/8) + c];
        e[c] = a[7 - (i % 8)];
      end
      checkOutput($sformatf("t3_cyc%0d", i), 32'(sd), {28'd0, e});
      checkOutput($sformatf("t3_underrun%0d", i), 32'(underrun), 32'd0);
    end
    checkOutput("t3_consumed", 32'(txQ.size()), 32'd0);

    // Two lanes, valid withheld for one word period
    applyStimulus(5'd7, 2'd1, 1'b0, 9'd0);
    w4 = '{8'hB1, 8'h4E, 8'hD2, 8'h2D};
    txQ.push_back({24'd0, w4[0]});
    txQ.push_back({24'd0, w4[1]});
    feedEn = 1'b1;
    waitReady("t4_rts");
    feedEn = 1'b0;
    txQ.push_back({24'd0, w4[2]});
    txQ.push_back({24'd0, w4[3]});
    ws = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick;
      e = 4'd0;
      if (i < 8) begin
        a = w4[0]; b = w4[1];
        e = {2'b00, b[7-i], a[7-i]};
      end else if (i >= 16) begin
        a = w4[2]; b = w4[3];
        e = {2'b00, b[7-(i-16)], a[7-(i-16)]};
      end
      checkOutput($sformatf("t4_cyc%0d", i), 32'(sd), {28'd0, e});
      checkOutput($sformatf("t4_underrun%0d", i), 32'(underrun), (i == 8) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t4_err%0d", i), 32'(err), (i >= 8) ? 32'd1 : 32'd0);
      if (i == 8) feedEn = 1'b1;
    end

    // Enable dropped mid-word, then re-armed with offset 2
    applyStimulus(5'd7, 2'd1, 1'b0, 9'd2);
    txQ.push_back(32'h000000C5);
    txQ.push_back(32'h0000003A);
    feedEn = 1'b1;
    waitReady("t5_rts");
    feedEn = 1'b0;
    ws = 1'b1;
    tick; checkOutput("t5_off0", 32'(sd), 32'd0);
    tick; checkOutput("t5_off1", 32'(sd), 32'd0);
    tick; checkOutput("t5_bit7", 32'(sd), 32'b01);
    tick; checkOutput("t5_bit6", 32'(sd), 32'b01);
    tick; checkOutput("t5_bit5", 32'(sd), 32'b10);
    cfgEn = 1'b0;
    tick;
    checkOutput("t5_dis_sd", 32'(sd), 32'd0);
    checkOutput("t5_dis_rts", 32'(readyToSend), 32'd0);
    checkOutput("t5_dis_ready", 32'(fifoReady), 32'd0);
    checkOutput("t5_dis_err", 32'(err), 32'd0);

    applyStimulus(5'd7, 2'd1, 1'b0, 9'd2);
    txQ.push_back(32'h00000096);
    txQ.push_back(32'h0000005C);
    feedEn = 1'b1;
    waitReady("t5_rts2");
    ws = 1'b1;
    tick; checkOutput("t5_reoff0", 32'(sd), 32'd0);
    tick; checkOutput("t5_reoff1", 32'(sd), 32'd0);
    a = 8'h96; b = 8'h5C;
    for (int i = 0; i < 8; i++) begin
      tick;
      checkOutput($sformatf("t5_re_bit%0d", i), 32'(sd), {30'd0, b[7-i], a[7-i]});
    end
    tick;
    checkOutput("t5_underrun", 32'(underrun), 32'd1);
    txQ.push_back(32'h000000E0);
    txQ.push_back(32'h00000060);
    repeat (7) tick;
    tick; checkOutput("t5_next_bit7", 32'(sd), 32'b01);
    tick; checkOutput("t5_next_bit6", 32'(sd), 32'b11);
    tick; checkOutput("t5_next_bit5", 32'(sd), 32'b11);

    // Asynchronous reset in the middle of a word
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("t6_sd", 32'(sd), 32'd0);
    checkOutput("t6_rts", 32'(readyToSend), 32'd0);
    checkOutput("t6_ready", 32'(fifoReady), 32'd0);
    checkOutput("t6_err", 32'(err), 32'd0);
    txQ.push_back(32'h00000055);
    repeat (3) tick;
    checkOutput("t6_no_handshake", 32'(txQ.size()), 32'd1);
    rstn = 1'b1;
    tick;
    checkOutput("t6_fill_ready", 32'(fifoReady), 32'd1);
    checkOutput("t6_still_queued", 32'(txQ.size()), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
